// File: rtl/connect4_pkg.sv
// Shared types and constants for the Connect-4 turn controller.
// state_t carries the fixed 4-bit state codes; ST_IDLE and ST_GAME_OVER
// are the codes the top-level video mux keys screen selection on.
package connect4_pkg;

    typedef enum logic [3:0] {
        StIdle      = 4'b0000,
        StP1Wait    = 4'b0001,
        StP1Check   = 4'b0010,
        StP2Wait    = 4'b0011,
        StP2Check   = 4'b0100,
        StP1Timeout = 4'b0101,
        StP2Timeout = 4'b0110,
        StGameOver  = 4'b1000
    } state_t;

    localparam state_t ST_IDLE      = StIdle;
    localparam state_t ST_GAME_OVER = StGameOver;

endpackage

// File: rtl/start_edge_detect.sv
// Rising-edge detector for one debounced start button.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-high; clears the previous-sample register
//   btn   - debounced button level
//   rise  - high for the cycle where btn is 1 and was 0 on the previous clock
module start_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic btn_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn;
        end
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/connect4_game_fsm.sv
// Two-player Connect-4 turn controller. Sequences start, alternating turns,
// timeout-driven random moves, win/draw detection and game over. Board state,
// move legality, win checking and the turn timer are external; only their
// status flags are consumed here.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   player1_start/2_start - debounced start buttons (level; edges start a game)
//   move_valid            - pulse: legal piece placed for the current player
//   winner_found          - level, sampled in CHECK states
//   board_full            - level, sampled in CHECK states
//   timer_done            - turn timer expired
//   reset_timer           - holds the external turn timer cleared
//   p1_turn / p2_turn     - which player owns the turn
//   game_over             - game finished
//   estado                - current 4-bit state code
//   random_move           - one-cycle request for a random legal move
//   player                - current or last mover (0 = P1, 1 = P2)
module connect4_game_fsm
    import connect4_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       player1_start,
    input  logic       player2_start,
    input  logic       move_valid,
    input  logic       winner_found,
    input  logic       board_full,
    input  logic       timer_done,
    output logic       reset_timer,
    output logic       p1_turn,
    output logic       p2_turn,
    output logic       game_over,
    output logic [3:0] estado,
    output logic       random_move,
    output logic       player
);

    logic   p1_rise;
    logic   p2_rise;
    state_t state_q, state_d;
    logic   player_q, player_d;
    logic   random_move_q, random_move_d;

    start_edge_detect u_p1_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (player1_start),
        .rise  (p1_rise)
    );

    start_edge_detect u_p2_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (player2_start),
        .rise  (p2_rise)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            player_q      <= 1'b0;
            random_move_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            player_q      <= player_d;
            random_move_q <= random_move_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        player_d = player_q;

        case (state_q)
            StIdle: begin
                // Simultaneous presses go to P1.
                if (p1_rise) begin
                    state_d  = StP1Wait;
                    player_d = 1'b0;
                end else if (p2_rise) begin
                    state_d  = StP2Wait;
                    player_d = 1'b1;
                end
            end
            StP1Wait: begin
                if (move_valid) begin
                    state_d = StP1Check;
                end else if (timer_done) begin
                    state_d = StP1Timeout;
                end
            end
            StP1Timeout: begin
                if (move_valid) begin
                    state_d = StP1Check;
                end
            end
            StP1Check: begin
                if (winner_found || board_full) begin
                    state_d = StGameOver;
                end else begin
                    state_d  = StP2Wait;
                    player_d = 1'b1;
                end
            end
            StP2Wait: begin
                if (move_valid) begin
                    state_d = StP2Check;
                end else if (timer_done) begin
                    state_d = StP2Timeout;
                end
            end
            StP2Timeout: begin
                if (move_valid) begin
                    state_d = StP2Check;
                end
            end
            StP2Check: begin
                if (winner_found || board_full) begin
                    state_d = StGameOver;
                end else begin
                    state_d  = StP1Wait;
                    player_d = 1'b0;
                end
            end
            StGameOver: begin
                // Only returns to IDLE; a later edge is needed to start play.
                if (p1_rise || p2_rise) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered pulse on entry into either timeout state.
        random_move_d = ((state_d == StP1Timeout) && (state_q != StP1Timeout)) ||
                        ((state_d == StP2Timeout) && (state_q != StP2Timeout));
    end

    always_comb begin
        estado      = state_q;
        p1_turn     = (state_q == StP1Wait) || (state_q == StP1Timeout) ||
                      (state_q == StP1Check);
        p2_turn     = (state_q == StP2Wait) || (state_q == StP2Timeout) ||
                      (state_q == StP2Check);
        game_over   = (state_q == ST_GAME_OVER);
        // Timer only runs while waiting on a human move.
        reset_timer = !((state_q == StP1Wait) || (state_q == StP2Wait));
        random_move = random_move_q;
        player      = player_q;
    end

endmodule

// File: tb/tb_connect4_game_fsm.sv
module tb_connect4_game_fsm;

    logic       clk;
    logic       reset;
    logic       player1_start;
    logic       player2_start;
    logic       move_valid;
    logic       winner_found;
    logic       board_full;
    logic       timer_done;
    logic       reset_timer;
    logic       p1_turn;
    logic       p2_turn;
    logic       game_over;
    logic [3:0] estado;
    logic       random_move;
    logic       player;

    int checks;
    int failures;

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } exp_t;

    exp_t sb[$];

    connect4_game_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .player1_start (player1_start),
        .player2_start (player2_start),
        .move_valid    (move_valid),
        .winner_found  (winner_found),
        .board_full    (board_full),
        .timer_done    (timer_done),
        .reset_timer   (reset_timer),
        .p1_turn       (p1_turn),
        .p2_turn       (p2_turn),
        .game_over     (game_over),
        .estado        (estado),
        .random_move   (random_move),
        .player        (player)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] IDLE  = 4'b0000;
    localparam logic [3:0] P1W   = 4'b0001;
    localparam logic [3:0] P1C   = 4'b0010;
    localparam logic [3:0] P2W   = 4'b0011;
    localparam logic [3:0] P2C   = 4'b0100;
    localparam logic [3:0] P1T   = 4'b0101;
    localparam logic [3:0] P2T   = 4'b0110;
    localparam logic [3:0] GOVER = 4'b1000;

    // Expected output vector:
    // {estado, reset_timer, p1_turn, p2_turn, game_over, random_move, player}
    function automatic logic [9:0] mk(input logic [3:0] st, input logic rm, input logic pl);
        logic rt, t1, t2, go;
        rt = !(st == P1W || st == P2W);
        t1 = (st == P1W || st == P1C || st == P1T);
        t2 = (st == P2W || st == P2C || st == P2T);
        go = (st == GOVER);
        return {st, rt, t1, t2, go, rm, pl};
    endfunction

    task automatic push(input string tag, input logic [3:0] st, input logic rm, input logic pl);
        exp_t e;
        e.tag = tag;
        e.exp = mk(st, rm, pl);
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t       e;
        logic [9:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = {estado, reset_timer, p1_turn, p2_turn, game_over, random_move, player};
            checks++;
            assert (obs === e.exp)
            else begin
                failures++;
                $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
            end
        end
    endtask

    // Check outputs now, without a clock edge.
    task automatic now(input string tag, input logic [3:0] st, input logic rm, input logic pl);
        push(tag, st, rm, pl);
        drain();
    endtask

    // Apply current inputs across one rising edge, then check.
    task automatic cyc(input string tag, input logic [3:0] st, input logic rm, input logic pl);
        push(tag, st, rm, pl);
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        player1_start = 1'b0;
        player2_start = 1'b0;
        move_valid    = 1'b0;
        winner_found  = 1'b0;
        board_full    = 1'b0;
        timer_done    = 1'b0;

        #3;
        now("rst_async", IDLE, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("idle_hold", IDLE, 1'b0, 1'b0);

        // Reset in the middle of P2_WAIT.
        player2_start = 1'b1;
        cyc("p2_start", P2W, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        now("rst_mid_p2", IDLE, 1'b0, 1'b0);
        player2_start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("post_rst", IDLE, 1'b0, 1'b0);

        // P1 start, move, fall through check to P2.
        player1_start = 1'b1;
        cyc("p1_start", P1W, 1'b0, 1'b0);
        cyc("p1_held", P1W, 1'b0, 1'b0);
        move_valid = 1'b1;
        cyc("p1_move", P1C, 1'b0, 1'b0);
        cyc("p1_chk_mv_ignored", P2W, 1'b0, 1'b1);
        move_valid    = 1'b0;
        player1_start = 1'b0;

        // P2 timeout with random move pulse, then move.
        timer_done = 1'b1;
        cyc("p2_timeout", P2T, 1'b1, 1'b1);
        cyc("p2_timeout_hold", P2T, 1'b0, 1'b1);
        timer_done = 1'b0;
        move_valid = 1'b1;
        cyc("p2_to_check", P2C, 1'b0, 1'b1);
        move_valid = 1'b0;
        cyc("p2_chk_to_p1", P1W, 1'b0, 1'b0);

        // move_valid beats timer_done; P1 wins.
        move_valid = 1'b1;
        timer_done = 1'b1;
        cyc("mv_beats_timer", P1C, 1'b0, 1'b0);
        move_valid   = 1'b0;
        timer_done   = 1'b0;
        winner_found = 1'b1;
        cyc("p1_win", GOVER, 1'b0, 1'b0);
        winner_found = 1'b0;
        cyc("go_hold", GOVER, 1'b0, 1'b0);
        player2_start = 1'b1;
        cyc("go_p2_edge", IDLE, 1'b0, 1'b0);
        cyc("idle_p2_held", IDLE, 1'b0, 1'b0);
        player2_start = 1'b0;

        // Simultaneous start edges; draw via board_full; held buttons.
        player1_start = 1'b1;
        player2_start = 1'b1;
        cyc("both_start", P1W, 1'b0, 1'b0);
        move_valid = 1'b1;
        cyc("p1_move2", P1C, 1'b0, 1'b0);
        move_valid = 1'b0;
        board_full = 1'b1;
        cyc("p1_full", GOVER, 1'b0, 1'b0);
        board_full = 1'b0;
        cyc("go_held_no_retrig", GOVER, 1'b0, 1'b0);
        player1_start = 1'b0;
        player2_start = 1'b0;
        cyc("go_released", GOVER, 1'b0, 1'b0);
        player2_start = 1'b1;
        cyc("go_p2_repress", IDLE, 1'b0, 1'b0);
        player2_start = 1'b0;
        move_valid    = 1'b1;
        cyc("idle_mv_ignored", IDLE, 1'b0, 1'b0);
        move_valid = 1'b0;

        // P1 timeout, then P2 wins from P2_CHECK.
        player1_start = 1'b1;
        cyc("p1_start2", P1W, 1'b0, 1'b0);
        player1_start = 1'b0;
        timer_done    = 1'b1;
        cyc("p1_timeout", P1T, 1'b1, 1'b0);
        timer_done = 1'b0;
        cyc("p1_timeout_wait", P1T, 1'b0, 1'b0);
        move_valid = 1'b1;
        cyc("p1t_to_check", P1C, 1'b0, 1'b0);
        move_valid = 1'b0;
        cyc("p1c_to_p2", P2W, 1'b0, 1'b1);
        move_valid = 1'b1;
        cyc("p2_move", P2C, 1'b0, 1'b1);
        move_valid   = 1'b0;
        winner_found = 1'b1;
        cyc("p2_win", GOVER, 1'b0, 1'b1);
        winner_found = 1'b0;
        cyc("go_p2_player", GOVER, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
